// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO window decode, register
// offsets and control state encodings.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [1:0]  IO_REGION = 2'b11;
    localparam logic [15:0] IO_CHAR   = 16'h0000;
    localparam logic [15:0] IO_CLK    = 16'h0004;
    localparam logic [15:0] IO_SNAP1  = 16'h0005;
    localparam logic [15:0] IO_SNAP2  = 16'h0006;
    localparam logic [15:0] IO_SNAP3  = 16'h0007;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

    function automatic logic [15:0] io_offset(input logic [17:0] addr);
        return addr[15:0] - IO_BASE[15:0];
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side byte-wide memory bus between the core (master) and the responder (slave).
interface mem_io_responder_if;

    logic [31:0] mem_a_in;
    logic [7:0]  mem_d_in;
    logic        mem_wr_in;
    logic [7:0]  mem_d_out;
    logic        io_buffer_full;
    logic        cpu_rdy_out;

    modport master (
        output mem_a_in, mem_d_in, mem_wr_in,
        input  mem_d_out, io_buffer_full, cpu_rdy_out
    );

    modport slave (
        input  mem_a_in, mem_d_in, mem_wr_in,
        output mem_d_out, io_buffer_full, cpu_rdy_out
    );

endinterface

// File: rtl/mem_io_responder_sync_fifo.sv
// Single-clock FIFO with a combinational head; push when full and pop when
// empty are silently ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign empty     = (count_r == '0);
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Far-side responder for the CPU memory bus: inline RAM, UART TX/RX FIFOs,
// free-running cycle counter with snapshot, and program-stop sequencing.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int    RAM_ADDR_WIDTH = 17,
    parameter string RAM_INIT_FILE  = "",
    parameter int    TX_DEPTH       = 8,
    parameter int    RX_DEPTH       = 8,
    parameter int    FULL_MARGIN    = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                halted
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic [7:0]  ram_r [2**RAM_ADDR_WIDTH];

    state_t      state_r;
    logic [31:0] counter_r;
    logic [31:0] snapshot_r;

    logic [17:0] addr_s;
    logic [15:0] io_off_s;
    logic        io_sel_s;
    logic        run_s;
    logic        rd_s;
    logic        wr_s;
    logic        halt_req_s;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx_s;

    logic        tx_push_s;
    logic [7:0]  tx_din_s;
    logic        tx_empty_s;
    logic        tx_full_s;
    logic [TXCW-1:0] tx_count_s;
    logic [TXCW-1:0] tx_cnt_next_s;
    logic [TXCW-1:0] tx_free_s;
    logic        tx_push_ok_s;
    logic        tx_pop_ok_s;

    logic        rx_pop_s;
    logic [7:0]  rx_dout_s;
    logic        rx_empty_s;
    logic        rx_full_s;
    logic [RXCW-1:0] rx_count_s;

    assign addr_s     = bus.mem_a_in[17:0];
    assign io_sel_s   = is_io_addr(addr_s);
    assign io_off_s   = io_offset(addr_s);
    assign ram_idx_s  = addr_s[RAM_ADDR_WIDTH-1:0];
    assign run_s      = (state_r == ST_RUN);
    assign rd_s       = run_s && !bus.mem_wr_in;
    assign wr_s       = run_s && bus.mem_wr_in;
    assign halt_req_s = wr_s && io_sel_s && (io_off_s == IO_CLK);
    assign rx_pop_s   = rd_s && io_sel_s && (io_off_s == IO_CHAR);

    assign tx_valid   = !tx_empty_s;

    // Select what the bus pushes into TX: a non-zero character, or the
    // terminating 0x00 that accompanies a stop request.
    always_comb begin
        tx_push_s = 1'b0;
        tx_din_s  = 8'h00;
        if (wr_s && io_sel_s && (io_off_s == IO_CHAR) && (bus.mem_d_in != 8'h00)) begin
            tx_push_s = 1'b1;
            tx_din_s  = bus.mem_d_in;
        end else if (halt_req_s) begin
            tx_push_s = 1'b1;
            tx_din_s  = 8'h00;
        end else begin
            tx_push_s = 1'b0;
            tx_din_s  = 8'h00;
        end
    end

    // Post-edge TX occupancy, so the near-full flag tracks the queue without lag.
    always_comb begin
        tx_push_ok_s  = tx_push_s && !tx_full_s;
        tx_pop_ok_s   = tx_ready && !tx_empty_s;
        tx_cnt_next_s = tx_count_s;
        if (tx_push_ok_s && !tx_pop_ok_s) begin
            tx_cnt_next_s = tx_count_s + TXCW'(1);
        end else if (!tx_push_ok_s && tx_pop_ok_s) begin
            tx_cnt_next_s = tx_count_s - TXCW'(1);
        end else begin
            tx_cnt_next_s = tx_count_s;
        end
        tx_free_s = TXCW'(TX_DEPTH) - tx_cnt_next_s;
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push_s),
        .pop   (tx_ready),
        .din   (tx_din_s),
        .dout  (tx_data),
        .empty (tx_empty_s),
        .full  (tx_full_s),
        .count (tx_count_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid),
        .pop   (rx_pop_s),
        .din   (rx_data),
        .dout  (rx_dout_s),
        .empty (rx_empty_s),
        .full  (rx_full_s),
        .count (rx_count_s)
    );

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_s && !io_sel_s) begin
            ram_r[ram_idx_s] <= bus.mem_d_in;
        end
    end

    // Read data, cycle counter, snapshot and near-full flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.mem_d_out      <= 8'h00;
            bus.io_buffer_full <= 1'b0;
            counter_r          <= 32'h0000_0000;
            snapshot_r         <= 32'h0000_0000;
        end else begin
            bus.io_buffer_full <= (tx_free_s <= TXCW'(FULL_MARGIN));
            if (run_s) begin
                counter_r <= counter_r + 32'd1;
            end
            if (rd_s && io_sel_s) begin
                case (io_off_s)
                    IO_CHAR:  bus.mem_d_out <= rx_empty_s ? 8'h00 : rx_dout_s;
                    IO_CLK: begin
                        bus.mem_d_out <= counter_r[7:0];
                        snapshot_r    <= counter_r;
                    end
                    IO_SNAP1: bus.mem_d_out <= snapshot_r[15:8];
                    IO_SNAP2: bus.mem_d_out <= snapshot_r[23:16];
                    IO_SNAP3: bus.mem_d_out <= snapshot_r[31:24];
                    default:  bus.mem_d_out <= 8'h00;
                endcase
            end else if (rd_s) begin
                bus.mem_d_out <= ram_r[ram_idx_s];
            end
        end
    end

    // Run / drain / stop sequencing with registered CPU pause and halted flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r         <= ST_RUN;
            bus.cpu_rdy_out <= 1'b1;
            halted          <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req_s) begin
                        state_r         <= ST_HALT_DRAIN;
                        bus.cpu_rdy_out <= 1'b0;
                    end else begin
                        bus.cpu_rdy_out <= 1'b1;
                    end
                    halted <= 1'b0;
                end
                ST_HALT_DRAIN: begin
                    bus.cpu_rdy_out <= 1'b0;
                    if (tx_empty_s) begin
                        state_r <= ST_HALTED;
                        halted  <= 1'b1;
                    end else begin
                        halted  <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    bus.cpu_rdy_out <= 1'b0;
                    halted          <= 1'b1;
                end
                default: begin
                    state_r         <= ST_RUN;
                    bus.cpu_rdy_out <= 1'b1;
                    halted          <= 1'b0;
                end
            endcase
        end
    end

endmodule
